// File: rtl/reg_file_reader.sv
// ----------------------------------------------------------------------------
// reg_file_reader
//
// 32-entry register file with one-hot write port and two registered read
// ports. Register 31 is hard-wired to zero. A write is accepted only when the
// write vector has exactly one bit set. A multi-hot vector suppresses the write
// and sets a sticky error flag. Reads take one cycle. An accepted write to the
// read address in the same cycle is forwarded to the read data.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   reset_n    : asynchronous active-low reset
//   wr_onehot  : [31:0] one-hot write select, bit i selects register i
//   wr_data    : [DATA_W-1:0] write data
//   rd_req     : read request strobe
//   rd_addr_a  : [4:0] port A read address
//   rd_addr_b  : [4:0] port B read address
//   rd_data_a  : [DATA_W-1:0] registered port A read data
//   rd_data_b  : [DATA_W-1:0] registered port B read data
//   rd_valid   : read data valid this cycle
//   wr_idx     : [4:0] binary index of the last accepted write
//   wr_err     : sticky multi-hot write error flag
// ----------------------------------------------------------------------------
module reg_file_reader #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       wr_onehot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic [4:0]        wr_idx,
    output logic              wr_err
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [DATA_W-1:0] regs [NREG];

    // Write-vector decode: binary index of the highest set bit, plus flags
    // telling whether any bit and more than one bit is set.
    logic [4:0] wr_bin;
    logic       wr_any;
    logic       wr_multi;
    logic       wr_accept;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_bin   = '0;
        wr_any   = 1'b0;
        wr_multi = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (wr_onehot[i]) begin
                if (wr_any) begin
                    wr_multi = 1'b1;
                end
                wr_any = 1'b1;
                wr_bin = 5'(i);
            end
        end
    end

    assign wr_accept = wr_any && !wr_multi;

    // Read muxes. Register 31 always reads zero and is never forwarded. An
    // accepted same-cycle write to the read address wins over stored contents.
    // A suppressed multi-hot write never forwards because wr_accept is low.
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    assign hit_a  = wr_accept && (wr_bin == rd_addr_a);
    assign hit_b  = wr_accept && (wr_bin == rd_addr_b);
    assign next_a = (rd_addr_a == ZERO_REG) ? '0 :
                    hit_a                   ? wr_data : regs[rd_addr_a];
    assign next_b = (rd_addr_b == ZERO_REG) ? '0 :
                    hit_b                   ? wr_data : regs[rd_addr_b];

    // Register storage. Entry 31 is cleared on reset and never written.
    // NOTE: the storage array is reset here because the design must read zero
    // from every register straight after reset. Without that requirement,
    // storage would normally be left unreset so it can map onto RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_accept && (wr_bin != ZERO_REG)) begin
            // NOTE: sequential state is written with non-blocking assignments,
            // so every flop samples the values from before the edge.
            regs[wr_bin] <= wr_data;
        end
    end

    // Read pipeline. When no read is requested, the data holds its value and
    // only the valid flag drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data_a <= next_a;
                rd_data_b <= next_b;
            end
        end
    end

    // Write status: wr_idx follows every accepted write, including writes to
    // index 31. wr_err is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx <= '0;
            wr_err <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_idx <= wr_bin;
            end
            if (wr_multi) begin
                wr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_reader.sv
// ----------------------------------------------------------------------------
// tb_reg_file_reader
//
// Self-checking bench for reg_file_reader. It runs three parts:
//   - a table of directed vectors applied in a loop from a known reset state
//   - hand-written sequences for sticky error and asynchronous reset
//   - randomized traffic compared against a behavioural model of the register
//     file
// ----------------------------------------------------------------------------
module tb_reg_file_reader;

    localparam int DATA_W = 64;

    logic              clk;
    logic              reset_n;
    logic [31:0]       wr_onehot;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [4:0]        rd_addr_a;
    logic [4:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid;
    logic [4:0]        wr_idx;
    logic              wr_err;

    reg_file_reader #(.DATA_W(DATA_W), .NREG(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_onehot (wr_onehot),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .wr_idx    (wr_idx),
        .wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mem [32];
    logic [63:0] m_a;
    logic [63:0] m_b;
    logic        m_valid;
    logic [4:0]  m_idx;
    logic        m_err;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_a = '0; m_b = '0; m_valid = 1'b0; m_idx = '0; m_err = 1'b0;
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] addr, input int ones,
                                               input int idx, input logic [63:0] d);
        if (addr == 5'd31)                  return 64'd0;
        if (ones == 1 && idx == int'(addr)) return d;
        return m_mem[addr];
    endfunction

    // Computes the effect of one rising edge from the inputs currently driven.
    task automatic model_edge();
        int ones;
        int idx;
        ones = $countones(wr_onehot);
        idx  = 0;
        for (int i = 0; i < 32; i++) if (wr_onehot[i]) idx = i;
        m_valid = rd_req;
        if (rd_req) begin
            m_a = model_read(rd_addr_a, ones, idx, wr_data);
            m_b = model_read(rd_addr_b, ones, idx, wr_data);
        end
        if (ones == 1) begin
            if (idx != 31) m_mem[idx] = wr_data;
            m_idx = 5'(idx);
        end else if (ones > 1) begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " rd_data_a"}, rd_data_a, m_a);
        check({tag, " rd_data_b"}, rd_data_b, m_b);
        check({tag, " rd_valid"},  64'(rd_valid), 64'(m_valid));
        check({tag, " wr_idx"},    64'(wr_idx),   64'(m_idx));
        check({tag, " wr_err"},    64'(wr_err),   64'(m_err));
    endtask

    // Drive the inputs, advance one edge, and sample 1 ns after that edge.
    task automatic step(input logic [31:0] oh, input logic [63:0] d, input logic rq,
                        input logic [4:0] aa, input logic [4:0] ab);
        wr_onehot = oh; wr_data = d; rd_req = rq; rd_addr_a = aa; rd_addr_b = ab;
        if (reset_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] oh;
        logic [63:0] d;
        logic        rq;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic [63:0] ea;
        logic [63:0] eb;
        logic        ev;
        logic [4:0]  ei;
        logic        ee;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Write then read back
        vecs[0] = '{32'h0000_0020, 64'hDEADBEEF_00000001, 1'b0, 5'd0,  5'd0,
                    64'h0, 64'h0, 1'b0, 5'd5, 1'b0};
        vecs[1] = '{32'h0000_0000, 64'h0, 1'b1, 5'd5, 5'd0,
                    64'hDEADBEEF_00000001, 64'h0, 1'b1, 5'd5, 1'b0};
        // Bypass on both ports
        vecs[2] = '{32'h0000_0080, 64'h1234, 1'b1, 5'd7, 5'd7,
                    64'h1234, 64'h1234, 1'b1, 5'd7, 1'b0};
        // Register 31 is never written or forwarded, but wr_idx still updates
        vecs[3] = '{32'h8000_0000, 64'hAAAA, 1'b1, 5'd5, 5'd31,
                    64'hDEADBEEF_00000001, 64'h0, 1'b1, 5'd31, 1'b0};
        // Write without read: data holds, valid drops
        vecs[4] = '{32'h0000_0004, 64'h55, 1'b0, 5'd0, 5'd0,
                    64'hDEADBEEF_00000001, 64'h0, 1'b0, 5'd2, 1'b0};
        vecs[5] = '{32'h0000_0000, 64'h0, 1'b1, 5'd2, 5'd2,
                    64'h55, 64'h55, 1'b1, 5'd2, 1'b0};
        // Idle hold
        vecs[6] = '{32'h0000_0000, 64'h0, 1'b0, 5'd9, 5'd9,
                    64'h55, 64'h55, 1'b0, 5'd2, 1'b0};
        // Multi-hot write: suppressed, no bypass, error set
        vecs[7] = '{32'h0000_0006, 64'hFF, 1'b1, 5'd1, 5'd2,
                    64'h0, 64'h55, 1'b1, 5'd2, 1'b1};
        vecs[8] = '{32'h0000_0000, 64'h0, 1'b1, 5'd1, 5'd2,
                    64'h0, 64'h55, 1'b1, 5'd2, 1'b1};
        vecs[9] = '{32'h0000_0000, 64'h0, 1'b1, 5'd7, 5'd31,
                    64'h1234, 64'h0, 1'b1, 5'd2, 1'b1};
    end

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0;
        wr_onehot = '0; wr_data = '0; rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data_a", rd_data_a, 64'h0);
        check("reset rd_data_b", rd_data_b, 64'h0);
        check("reset rd_valid",  64'(rd_valid), 64'h0);
        check("reset wr_idx",    64'(wr_idx),   64'h0);
        check("reset wr_err",    64'(wr_err),   64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].oh, vecs[i].d, vecs[i].rq, vecs[i].aa, vecs[i].ab);
            check($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].ea);
            check($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].eb);
            check($sformatf("vec%0d rd_valid", i),  64'(rd_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d wr_idx", i),    64'(wr_idx),   64'(vecs[i].ei));
            check($sformatf("vec%0d wr_err", i),    64'(wr_err),   64'(vecs[i].ee));
        end

        // wr_err stays set across ten idle cycles
        repeat (10) step(32'h0, 64'h0, 1'b0, 5'd0, 5'd0);
        check("sticky wr_err", 64'(wr_err), 64'h1);

        // Asynchronous reset in mid-cycle, with a read and a write pending
        step(32'h0000_1000, 64'hCAFE, 1'b1, 5'd7, 5'd5);
        wr_onehot = 32'h0000_0008; wr_data = 64'hBEEF; rd_req = 1'b1;
        rd_addr_a = 5'd3; rd_addr_b = 5'd12;
        #3;
        reset_n = 1'b0;
        #1;
        check("async rd_data_a", rd_data_a, 64'h0);
        check("async rd_data_b", rd_data_b, 64'h0);
        check("async rd_valid",  64'(rd_valid), 64'h0);
        check("async wr_idx",    64'(wr_idx),   64'h0);
        check("async wr_err",    64'(wr_err),   64'h0);
        model_reset();
        // An edge during reset must be ignored
        @(posedge clk);
        #1;
        check("in-reset rd_valid", 64'(rd_valid), 64'h0);
        check("in-reset wr_idx",   64'(wr_idx),   64'h0);
        reset_n = 1'b1;
        step(32'h0, 64'h0, 1'b0, 5'd0, 5'd0);
        check("post-reset rd_valid", 64'(rd_valid), 64'h0);
        step(32'h0, 64'h0, 1'b1, 5'd12, 5'd5);
        check("post-reset reg12", rd_data_a, 64'h0);
        check("post-reset reg5",  rd_data_b, 64'h0);
        step(32'h0, 64'h0, 1'b1, 5'd3, 5'd7);
        check("post-reset reg3", rd_data_a, 64'h0);
        check("post-reset reg7", rd_data_b, 64'h0);
        check_model("post-reset model");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] oh;
            logic [63:0] d;
            logic [4:0]  aa;
            logic [4:0]  ab;
            int          sel;
            sel = $urandom_range(0, 99);
            if (sel < 25)      oh = 32'h0;
            else if (sel < 88) oh = 32'h1 << $urandom_range(0, 31);
            else               oh = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31)) | 32'h1;
            if (sel >= 88 && $countones(oh) < 2) oh = oh | 32'h2;
            d  = {$urandom, $urandom};
            aa = 5'($urandom_range(0, 31));
            ab = 5'($urandom_range(0, 31));
            // Aim reads at the write target part of the time to exercise bypass
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 32; i++) if (oh[i]) aa = 5'(i);
            end
            step(oh, d, 1'($urandom_range(0, 1)), aa, ab);
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
